booth_mult_arbiter: RTL
=======================

// Module: booth_mult_arbiter
// PURPOSE
//   Shares one sequential Booth multiplier (start/done handshake) between N_REQ
//   requesters. Uses round-robin arbitration: one multiply in flight at a time.
//   Captures the winner's operands, pulses the multiplier start and waits for done.
//   Then returns the product to the winner, or an error if a watchdog expires.
//   Sits between client blocks and the multiplier datapath/controller pair.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   WIDTH    8   operand width; product is 2*WIDTH
//   TIMEOUT  64  max WAIT cycles before the job is failed (>= 2)
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            synchronous, active-high reset
//   req          in   N_REQ        level request, one bit per requester
//   a_in         in   N_REQ*WIDTH  multiplicand; requester i owns bits [i*WIDTH +: WIDTH]
//   b_in         in   N_REQ*WIDTH  multiplier, same packing as a_in
//   gnt          out  N_REQ        one-hot, 1-cycle pulse when operands are captured
//   rsp_valid    out  N_REQ        one-hot, 1-cycle pulse when the result is available
//   rsp_product  out  2*WIDTH      result, valid while any rsp_valid bit is high
//   rsp_err      out  1            high with rsp_valid on timeout
//   mul_start    out  1            1-cycle start pulse to the multiplier
//   mul_a        out  WIDTH        latched multiplicand to the multiplier
//   mul_b        out  WIDTH        latched multiplier operand to the multiplier
//   mul_done     in   1            multiplier completion, level or pulse
//   mul_product  in   2*WIDTH      multiplier result, sampled when mul_done=1 in WAIT
//   busy         out  1            high in every state except IDLE
// BEHAVIOUR
//   Reset values (rst=1 at a clock edge):
//   - state=IDLE, rr_ptr=0, wdog=0
//   - gnt, rsp_valid, rsp_err, mul_start, busy, mul_a, mul_b, rsp_product all 0
//   FSM, one state per cycle unless noted:
//   - IDLE: if |req, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//     Store its index in sel, then go to GRANT. Otherwise stay in IDLE.
//   - GRANT: gnt[sel]=1; latch mul_a/mul_b from a_in/b_in slice sel; then START.
//   - START: mul_start=1; wdog cleared to 0; then WAIT.
//   - WAIT: wdog increments each cycle; mul_done is sampled only in this state.
//     On mul_done=1: register mul_product into rsp_product, rsp_err=0, go to RESP.
//     Else if wdog==TIMEOUT-1: rsp_product=0, rsp_err=1, go to RESP.
//     If mul_done and wdog==TIMEOUT-1 occur together, done wins (rsp_err=0).
//   - RESP: rsp_valid[sel]=1; rr_ptr=(sel+1) mod N_REQ; then IDLE.
//     rsp_product and rsp_err hold until the next RESP.
//   Timing:
//   - Latency: req sampled in IDLE at edge t gives gnt at t+1, mul_start at t+2.
//   - rsp_valid appears 1 cycle after the done cycle.
//   - Minimum turnaround is 5 cycles when done arrives in the first WAIT cycle.
//   Handshake rules:
//   - Requester holds req and operands stable until it sees gnt.
//   - Requester drops req in the cycle after gnt unless it wants another job.
//   - req and operands are ignored outside IDLE/GRANT.
//   - A req still high at the next IDLE is arbitrated as a new request.
//   - Requesters cannot cancel a job; req dropping after gnt has no effect.
//   Arbitration and datapath:
//   - Exactly one job at a time; gnt and rsp_valid are always one-hot or zero.
//   - mul_done arriving in IDLE, GRANT, START or RESP is ignored.
//   - The multiplier is not told of a timeout; it must be restartable by mul_start.
//   - wdog is clog2(TIMEOUT) bits and saturates, no wrap.
//   - rr_ptr wraps from N_REQ-1 to 0.
//   Reset mid-operation: return to IDLE next cycle; no rsp_valid for the in-flight job.
// TESTING
//   1 req=0001, a=8'd7, b=-8'd3, done 4 cycles after start
//     -> gnt=0001 @t+1, mul_start @t+2, rsp_valid=0001, rsp_product=-21, rsp_err=0.
//   2 req=1111 held, rr_ptr=0
//     -> grant order 0,1,2,3,0; no requester granted twice within 4 jobs.
//   3 req=0100 while req[1] held after its job, rr_ptr=2
//     -> requester 2 granted before requester 1 is re-granted.
//   4 mul_done never asserted, TIMEOUT=64
//     -> rsp_valid exactly 64 WAIT cycles after START, rsp_err=1, rsp_product=0.
//   5 mul_done coincident with wdog==TIMEOUT-1
//     -> rsp_err=0, product taken from mul_product.
//   6 rst=1 for 1 cycle during WAIT
//     -> busy=0 next cycle, no rsp_valid, next grant starts from requester 0.

Source files
------------

// File: rtl/booth_mult_arbiter_if.sv
// Bundle between the requesters, the shared Booth multiplier and the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the clients and the multiplier.
interface booth_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_err;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;
  logic                   busy;

  modport slave (
    input  req, a_in, b_in, mul_done, mul_product,
    output gnt, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy
  );

  modport master (
    output req, a_in, b_in, mul_done, mul_product,
    input  gnt, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier among N_REQ clients,
// with a watchdog that fails a job whose done never arrives.
module booth_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  booth_mult_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      sel_reg, sel_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [WW-1:0]      wdog_reg, wdog_next;
  logic [WIDTH-1:0]   mul_a_reg, mul_a_next;
  logic [WIDTH-1:0]   mul_b_reg, mul_b_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic               err_reg, err_next;
  logic [IW-1:0]      pick;
  logic               pick_valid;

  logic [WIDTH-1:0]   a_slice [N_REQ];
  logic [WIDTH-1:0]   b_slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : gen_port
      assign a_slice[gi]       = bus.a_in[gi*WIDTH +: WIDTH];
      assign b_slice[gi]       = bus.b_in[gi*WIDTH +: WIDTH];
      assign bus.gnt[gi]       = (state_reg == S_GRANT) && (sel_reg == IW'(gi));
      assign bus.rsp_valid[gi] = (state_reg == S_RESP)  && (sel_reg == IW'(gi));
    end
  endgenerate

  assign bus.mul_start   = (state_reg == S_START);
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.mul_a       = mul_a_reg;
  assign bus.mul_b       = mul_b_reg;
  assign bus.rsp_product = prod_reg;
  assign bus.rsp_err     = err_reg;

  // Scan from the farthest offset down so the requester closest to rr_ptr wins last.
  always_comb begin
    int k;
    k          = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      k = int'(rr_ptr_reg) + off;
      if (k >= N_REQ) k = k - N_REQ;
      if (bus.req[IW'(k)]) begin
        pick       = IW'(k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    rr_ptr_next = rr_ptr_reg;
    wdog_next   = wdog_reg;
    mul_a_next  = mul_a_reg;
    mul_b_next  = mul_b_reg;
    prod_next   = prod_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          sel_next   = pick;
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        mul_a_next = a_slice[sel_reg];
        mul_b_next = b_slice[sel_reg];
        state_next = S_START;
      end
      S_START: begin
        wdog_next  = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        wdog_next = (wdog_reg == {WW{1'b1}}) ? wdog_reg : wdog_reg + WW'(1);
        // A done in the final watchdog cycle still counts as success.
        if (bus.mul_done) begin
          prod_next  = bus.mul_product;
          err_next   = 1'b0;
          state_next = S_RESP;
        end else if (wdog_reg == WW'(TIMEOUT - 1)) begin
          prod_next  = '0;
          err_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rr_ptr_next = (sel_reg == IW'(N_REQ - 1)) ? '0 : sel_reg + IW'(1);
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      sel_reg    <= '0;
      rr_ptr_reg <= '0;
      wdog_reg   <= '0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      prod_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      rr_ptr_reg <= rr_ptr_next;
      wdog_reg   <= wdog_next;
      mul_a_reg  <= mul_a_next;
      mul_b_reg  <= mul_b_next;
      prod_reg   <= prod_next;
      err_reg    <= err_next;
    end
  end
endmodule
